scarv_cop_cprs_ctrl: RTL and testbench
======================================

Name: scarv_cop_cprs_ctrl

Overview:
Write-port controller for the COP general purpose register file. It shares the file's single write port (crd_wen/crd_addr/crd_wdata) between NREQ requesters (e.g. PALU, memory load return, RNG) using valid/ready handshakes and round-robin arbitration. It also runs the xc.init clear sequence, zeroing all 16 registers one per cycle. It keeps a per-register "written since init" mask for hazard checks and tracing.

Parameters:
NREQ, 3, number of write requesters (2..8)
NREGS, 16, number of COP registers; the address width is fixed at 4

Ports:
g_clk  in  1  global clock
g_resetn  in  1  reset, synchronous, active-low
g_clk_req  out  1  clock request
init  in  1  xc.init executing; level, held until init_done is seen
init_done  out  1  clear sequence complete
req_valid  in  NREQ  per-requester write request
req_ready  out  NREQ  per-requester accept, one-hot or zero
req_addr  in  NREQ*4  flattened register address, requester i at [4i+3:4i]
req_wen  in  NREQ*4  flattened byte-lane enables
req_wdata  in  NREQ*32  flattened write data
crd_wen  out  4  to register file write enable
crd_addr  out  4  to register file write address
crd_wdata  out  32  to register file write data
cprs_valid  out  16  bit r = register r written since last init or reset

Behaviour:
- Reset values (g_resetn low at a clock edge):
  - state=IDLE, clr_cnt=0, rr_ptr=0, cprs_valid=0.
  - Outputs: init_done=0, req_ready=0, crd_wen=0.
- Write path is combinational, zero latency. An accepted request's write lands in the register file at the same clock edge as the handshake.
- State machine: IDLE, CLEAR, DONE.
- IDLE:
  - Arbitration runs. Search req_valid starting at rr_ptr, wrapping modulo NREQ; the first valid index g is granted.
  - req_ready[g]=1 and the crd_* outputs mirror requester g's slice.
  - Accept condition is req_valid[g] & req_ready[g]. On accept, rr_ptr <= (g+1) mod NREQ.
  - With no request pending: crd_wen=0, crd_addr=0, crd_wdata=0, rr_ptr unchanged.
  - req_ready may depend combinationally on req_valid. Requesters must hold valid, addr, wen and wdata stable until accepted.
  - req_wen=0 with valid=1 is still accepted and consumes the grant. No write occurs and cprs_valid is unchanged.
  - init=1 moves to CLEAR at the next edge, with clr_cnt=0. In that same cycle arbitration is suppressed: req_ready=0, crd_wen=0.
- CLEAR:
  - Each cycle drives crd_wen=4'hF, crd_addr=clr_cnt, crd_wdata=0, and sets cprs_valid[clr_cnt].
  - clr_cnt increments each cycle. After clr_cnt=15 the state moves to DONE. This is exactly 16 write cycles.
  - req_ready=0 throughout.
  - cprs_valid is cleared to 0 on the IDLE->CLEAR transition, before the first clear write.
- DONE:
  - init_done=1, req_ready=0, crd_wen=0.
  - Stays in DONE while init=1. init=0 moves to IDLE the next cycle.
- init falling while in CLEAR: abort to IDLE. Registers already cleared stay cleared, cprs_valid keeps its partial bits, init_done never asserts.
- Reset mid-CLEAR: immediate return to reset values. Register contents are not touched by this block.
- cprs_valid in IDLE: an accepted write with crd_wen != 0 sets bit crd_addr.
- rr_ptr is held through CLEAR and DONE.
- g_clk_req = |req_valid | (state != IDLE) | init.
- init_done is a registered state decode, so it is glitch-free.

Decomposition:
- Shared package scarv_cop_pkg:
  - constants for the number of registers (16) and address width (4);
  - state encoding CPRS_CTRL_IDLE=2'd0, CLEAR=2'd1, DONE=2'd2;
  - the clear write pattern (wen 4'hF, data 0).
- One sub-module: scarv_cop_rr_arb (parameter NREQ).
  - Inputs: req, ptr, enable.
  - Outputs: one-hot grant and binary grant index.
  - Reused later for read-port sharing.
- The init FSM, mask and muxing stay in the top module.

Test Plan:
- Reset, then init=1 held: crd_addr goes 0..15 over 16 consecutive cycles with crd_wen=F and crd_wdata=0; init_done=1 on cycle 18; cprs_valid=16'hFFFF; after init drops, IDLE the next cycle.
- All three requesters valid continuously from IDLE with rr_ptr=0: grant order 0,1,2,0,1,2; each requester gets 2 accepts in 6 cycles; crd_addr/crd_wdata match the granted slice exactly.
- Requester 1 alone, addr=5, wen=4'b0011, wdata=32'hDEADBEEF: same-cycle accept; crd_wen=3, crd_addr=5; cprs_valid[5] set; rr_ptr becomes 2.
- Requester 2 valid with wen=0: accepted in 1 cycle; crd_wen=0; cprs_valid unchanged.
- init dropped after 7 clear cycles: state returns to IDLE; cprs_valid=16'h007F; init_done stays 0; arbitration resumes the next cycle.
- g_resetn low during CLEAR at clr_cnt=9: the next cycle shows crd_wen=0, cprs_valid=0, init_done=0; a pending request is accepted one cycle after g_resetn rises.

Source files
------------

// File: rtl/scarv_cop_pkg.sv
// Shared definitions for the COP register-file control blocks.
//   - register count and register address width
//   - CPRS controller state encoding (kept as plain 2-bit constants so that
//     existing trace and debug tooling keeps decoding the same values)
//   - the write pattern used by the xc.init clear sequence
package scarv_cop_pkg;

    localparam int unsigned CPRS_NREGS = 16;
    localparam int unsigned CPRS_AW    = 4;

    localparam logic [1:0] CPRS_CTRL_IDLE  = 2'd0;
    localparam logic [1:0] CPRS_CTRL_CLEAR = 2'd1;
    localparam logic [1:0] CPRS_CTRL_DONE  = 2'd2;

    localparam logic [3:0]  CPRS_CLR_WEN  = 4'hF;
    localparam logic [31:0] CPRS_CLR_DATA = 32'h0000_0000;

    // Pointer width for an NREQ-way round-robin pointer (at least 1 bit).
    function automatic int unsigned rr_ptr_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/scarv_cop_rr_arb.sv
// Combinational round-robin arbiter.
//   req_i       : per-requester request
//   ptr_i       : index with highest priority this cycle
//   enable_i    : when low, no grant is issued
//   grant_o     : one-hot grant (or zero)
//   grant_idx_o : binary index of the granted requester (0 when none)
// The search starts at ptr_i and wraps modulo NREQ; the first requesting
// index wins. Pointer update is left to the instantiating block.
module scarv_cop_rr_arb #(
    parameter int unsigned NREQ = 3,
    parameter int unsigned PW   = 2
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [PW-1:0]   ptr_i,
    input  logic            enable_i,
    output logic [NREQ-1:0] grant_o,
    output logic [PW-1:0]   grant_idx_o
);

    int unsigned cand;
    logic        found;

    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        found       = 1'b0;
        cand        = 0;
        for (int unsigned off = 0; off < NREQ; off++) begin
            cand = (32'(ptr_i) + off) % NREQ;
            if (enable_i && !found && req_i[cand[PW-1:0]]) begin
                grant_o[cand[PW-1:0]] = 1'b1;
                grant_idx_o           = cand[PW-1:0];
                found                 = 1'b1;
            end
        end
    end

endmodule

// File: rtl/scarv_cop_cprs.sv
// COP register-file write-port controller.
//   g_clk, g_resetn : clock, synchronous active-low reset
//   g_clk_req       : clock request (requests pending, busy, or init)
//   init, init_done : xc.init clear handshake
//   req_*           : NREQ flattened write requesters (valid/ready)
//   crd_*           : register-file write port
//   cprs_valid      : per-register "written since last init or reset"
// Requesters share the single write port via a round-robin arbiter; the
// write path is combinational so an accepted write lands on the same edge
// as its handshake. The clear sequence writes zero to every register, one
// per cycle.
module scarv_cop_cprs_ctrl
    import scarv_cop_pkg::*;
#(
    parameter int unsigned NREQ  = 3,
    parameter int unsigned NREGS = CPRS_NREGS
) (
    input  logic              g_clk,
    input  logic              g_resetn,
    output logic              g_clk_req,
    input  logic              init,
    output logic              init_done,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*4-1:0] req_addr,
    input  logic [NREQ*4-1:0] req_wen,
    input  logic [NREQ*32-1:0] req_wdata,
    output logic [3:0]        crd_wen,
    output logic [3:0]        crd_addr,
    output logic [31:0]       crd_wdata,
    output logic [NREGS-1:0]  cprs_valid
);

    localparam int unsigned PW = rr_ptr_width(NREQ);

    logic [1:0]         state_q,   state_d;
    logic [CPRS_AW-1:0] clr_cnt_q, clr_cnt_d;
    logic [PW-1:0]      rr_ptr_q,  rr_ptr_d;
    logic [NREGS-1:0]   cprs_q,    cprs_d;

    logic               arb_en;
    logic [NREQ-1:0]    grant;
    logic [PW-1:0]      grant_idx;

    // Arbitration is suppressed during reset, outside IDLE, and in the
    // cycle where init is seen so the clear sequence starts cleanly.
    assign arb_en = g_resetn && (state_q == CPRS_CTRL_IDLE) && !init;

    scarv_cop_rr_arb #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_arb (
        .req_i       (req_valid),
        .ptr_i       (rr_ptr_q),
        .enable_i    (arb_en),
        .grant_o     (grant),
        .grant_idx_o (grant_idx)
    );

    // Write-port mux.
    always_comb begin
        req_ready = grant;
        crd_wen   = '0;
        crd_addr  = '0;
        crd_wdata = '0;
        if (g_resetn && (state_q == CPRS_CTRL_CLEAR)) begin
            crd_wen   = CPRS_CLR_WEN;
            crd_addr  = clr_cnt_q;
            crd_wdata = CPRS_CLR_DATA;
        end else begin
            for (int unsigned i = 0; i < NREQ; i++) begin
                if (grant[i]) begin
                    crd_wen   = req_wen  [4*i  +: 4];
                    crd_addr  = req_addr [4*i  +: 4];
                    crd_wdata = req_wdata[32*i +: 32];
                end
            end
        end
    end

    // Next state, clear counter, round-robin pointer and written mask.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        rr_ptr_d  = rr_ptr_q;
        cprs_d    = cprs_q;
        case (state_q)
            CPRS_CTRL_IDLE: begin
                clr_cnt_d = '0;
                if (init) begin
                    state_d = CPRS_CTRL_CLEAR;
                    cprs_d  = '0;
                end else if (|grant) begin
                    rr_ptr_d = (grant_idx == PW'(NREQ-1)) ? '0
                                                          : grant_idx + PW'(1);
                    if (crd_wen != 4'h0) begin
                        cprs_d[crd_addr] = 1'b1;
                    end
                end
            end
            CPRS_CTRL_CLEAR: begin
                cprs_d[clr_cnt_q] = 1'b1;
                clr_cnt_d         = clr_cnt_q + 4'd1;
                // An init drop aborts; partial clear and mask bits persist.
                if (!init) begin
                    state_d = CPRS_CTRL_IDLE;
                end else if (clr_cnt_q == 4'hF) begin
                    state_d = CPRS_CTRL_DONE;
                end
            end
            CPRS_CTRL_DONE: begin
                if (!init) begin
                    state_d = CPRS_CTRL_IDLE;
                end
            end
            default: begin
                state_d = CPRS_CTRL_IDLE;
            end
        endcase
    end

    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            state_q   <= CPRS_CTRL_IDLE;
            clr_cnt_q <= '0;
            rr_ptr_q  <= '0;
            cprs_q    <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            rr_ptr_q  <= rr_ptr_d;
            cprs_q    <= cprs_d;
        end
    end

    assign init_done  = (state_q == CPRS_CTRL_DONE);
    assign cprs_valid = cprs_q;
    assign g_clk_req  = (|req_valid) || (state_q != CPRS_CTRL_IDLE) || init;

endmodule

// File: tb/tb_scarv_cop_cprs_ctrl.sv
module tb_scarv_cop_cprs_ctrl;

    logic         g_clk = 1'b0;
    logic         g_resetn;
    logic         g_clk_req;
    logic         init;
    logic         init_done;
    logic [2:0]   req_valid;
    logic [2:0]   req_ready;
    logic [11:0]  req_addr;
    logic [11:0]  req_wen;
    logic [95:0]  req_wdata;
    logic [3:0]   crd_wen;
    logic [3:0]   crd_addr;
    logic [31:0]  crd_wdata;
    logic [15:0]  cprs_valid;

    scarv_cop_cprs_ctrl #(
        .NREQ  (3),
        .NREGS (16)
    ) dut (
        .g_clk      (g_clk),
        .g_resetn   (g_resetn),
        .g_clk_req  (g_clk_req),
        .init       (init),
        .init_done  (init_done),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_wen    (req_wen),
        .req_wdata  (req_wdata),
        .crd_wen    (crd_wen),
        .crd_addr   (crd_addr),
        .crd_wdata  (crd_wdata),
        .cprs_valid (cprs_valid)
    );

    always #5 g_clk = ~g_clk;

    typedef struct {
        logic [2:0]  ready;
        logic [3:0]  wen;
        logic [3:0]  addr;
        logic [31:0] data;
    } exp_t;

    exp_t expq[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;
    int   acc_cnt[3] = '{0, 0, 0};

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    task automatic push(input logic [2:0] r, input logic [3:0] w,
                        input logic [3:0] a, input logic [31:0] d);
        exp_t x;
        x.ready = r; x.wen = w; x.addr = a; x.data = d;
        expq.push_back(x);
    endtask

    task automatic set_slot(input int i, input logic [3:0] a,
                            input logic [3:0] w, input logic [31:0] d);
        req_addr [4*i  +: 4]  = a;
        req_wen  [4*i  +: 4]  = w;
        req_wdata[32*i +: 32] = d;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge g_clk);
        #1;
    endtask

    // Monitor: every cycle that presents a grant or a write pops one entry.
    always @(negedge g_clk) begin
        if (g_resetn === 1'b1 && ((|req_ready) || (crd_wen != 4'h0))) begin
            if (expq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: ready=%b wen=%h addr=%h data=%h expected none",
                         req_ready, crd_wen, crd_addr, crd_wdata);
            end else begin
                e = expq.pop_front();
                check("req_ready", 32'(req_ready), 32'(e.ready));
                check("crd_wen",   32'(crd_wen),   32'(e.wen));
                check("crd_addr",  32'(crd_addr),  32'(e.addr));
                check("crd_wdata", crd_wdata,      e.data);
            end
            for (int i = 0; i < 3; i++) begin
                if (req_ready[i]) acc_cnt[i]++;
            end
        end
    end

    initial begin
        g_resetn  = 1'b0;
        init      = 1'b0;
        req_valid = '0;
        req_addr  = '0;
        req_wen   = '0;
        req_wdata = '0;

        // Reset state
        tick(2);
        check("rst_init_done", 32'(init_done),  32'h0);
        check("rst_cprs",      32'(cprs_valid), 32'h0);
        check("rst_ready",     32'(req_ready),  32'h0);
        check("rst_wen",       32'(crd_wen),    32'h0);
        g_resetn = 1'b1;
        tick(1);

        // All three requesters valid from rr_ptr=0: order 0,1,2,0,1,2
        for (int i = 0; i < 3; i++) set_slot(i, 4'(8 + i), 4'hF, 32'hA000_0000 + 32'(i));
        push(3'b001, 4'hF, 4'h8, 32'hA000_0000);
        push(3'b010, 4'hF, 4'h9, 32'hA000_0001);
        push(3'b100, 4'hF, 4'hA, 32'hA000_0002);
        push(3'b001, 4'hF, 4'h8, 32'hA000_0000);
        push(3'b010, 4'hF, 4'h9, 32'hA000_0001);
        push(3'b100, 4'hF, 4'hA, 32'hA000_0002);
        req_valid = 3'b111;
        tick(6);
        req_valid = 3'b000;
        check("acc_cnt0", 32'(acc_cnt[0]), 32'd2);
        check("acc_cnt1", 32'(acc_cnt[1]), 32'd2);
        check("acc_cnt2", 32'(acc_cnt[2]), 32'd2);
        check("rr_cprs", 32'(cprs_valid), 32'h0000_0700);

        // Requester 1 alone: addr 5, wen 3
        set_slot(1, 4'h5, 4'b0011, 32'hDEAD_BEEF);
        push(3'b010, 4'h3, 4'h5, 32'hDEAD_BEEF);
        req_valid = 3'b010;
        tick(1);
        req_valid = 3'b000;
        check("r1_cprs", 32'(cprs_valid), 32'h0000_0720);

        // rr_ptr should now be 2: with all valid, requester 2 wins
        push(3'b100, 4'hF, 4'hA, 32'hA000_0002);
        req_valid = 3'b111;
        tick(1);
        req_valid = 3'b000;

        // Requester 2 with wen=0: accepted, mask unchanged
        set_slot(2, 4'h3, 4'h0, 32'h1234_5678);
        push(3'b100, 4'h0, 4'h3, 32'h1234_5678);
        req_valid = 3'b100;
        tick(1);
        req_valid = 3'b000;
        check("wen0_cprs", 32'(cprs_valid), 32'h0000_0720);

        // Full clear sequence
        for (int i = 0; i < 16; i++) push(3'b000, 4'hF, 4'(i), 32'h0);
        init = 1'b1;
        tick(16);
        check("clr_init_done_early", 32'(init_done), 32'h0);
        tick(1);
        check("clr_init_done", 32'(init_done),  32'h1);
        check("clr_cprs",      32'(cprs_valid), 32'h0000_FFFF);
        tick(1);
        check("done_hold", 32'(init_done), 32'h1);
        init = 1'b0;
        tick(1);
        check("idle_init_done", 32'(init_done), 32'h0);
        check("idle_clk_req",   32'(g_clk_req), 32'h0);

        // Abort after 7 clear writes, arbitration resumes next cycle
        for (int i = 0; i < 7; i++) push(3'b000, 4'hF, 4'(i), 32'h0);
        init = 1'b1;
        tick(7);
        init = 1'b0;
        set_slot(0, 4'hC, 4'b0101, 32'h0BAD_F00D);
        push(3'b001, 4'b0101, 4'hC, 32'h0BAD_F00D);
        req_valid = 3'b001;
        tick(1);
        check("abort_init_done", 32'(init_done),  32'h0);
        check("abort_cprs",      32'(cprs_valid), 32'h0000_007F);
        tick(1);
        req_valid = 3'b000;
        check("resume_cprs", 32'(cprs_valid), 32'h0000_107F);

        // Reset during CLEAR at clr_cnt=9
        for (int i = 0; i < 9; i++) push(3'b000, 4'hF, 4'(i), 32'h0);
        init = 1'b1;
        tick(10);
        g_resetn = 1'b0;
        init     = 1'b0;
        set_slot(1, 4'h7, 4'b1100, 32'hCAFE_F00D);
        req_valid = 3'b010;
        tick(1);
        check("mrst_wen",       32'(crd_wen),    32'h0);
        check("mrst_cprs",      32'(cprs_valid), 32'h0);
        check("mrst_init_done", 32'(init_done),  32'h0);
        push(3'b010, 4'b1100, 4'h7, 32'hCAFE_F00D);
        g_resetn = 1'b1;
        tick(1);
        req_valid = 3'b000;
        check("post_rst_cprs", 32'(cprs_valid), 32'h0000_0080);

        tick(2);
        check("queue_drained", 32'(expq.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
